// File: rtl/encoder83_pkg.sv
// Shared widths, typedefs and constants for the 8-to-3 priority encoder.
package encoder83_pkg;
  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef logic [ENC_IN_W-1:0]  enc_in_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

  localparam enc_idx_t ENC_IDX_NONE = 3'd0;
endpackage

// File: rtl/encoder_83_if.sv
// Request/response bundle of encoder_83; the master drives requests, the encoder answers.
interface encoder_83_if;
  import encoder83_pkg::*;

  logic     iEn;
  enc_in_t  iData;
  enc_idx_t oData;
  logic     oValid;
  logic     oMulti;

  modport master (output iEn, output iData, input oData, input oValid, input oMulti);
  modport slave  (input iEn, input iData, output oData, output oValid, output oMulti);
endinterface

// File: rtl/encoder83_core.sv
// Combinational priority encoder: index of highest set bit, any-set flag and,
// with ENCODER83_MULTI_DETECT_EN defined, a two-or-more-bits-set flag.
module encoder83_core
  import encoder83_pkg::*;
(
  input  enc_in_t  data_i,
  output enc_idx_t idx_o,
`ifdef ENCODER83_MULTI_DETECT_EN
  output logic     multi_o,
`endif
  output logic     valid_o
);

  // Ascending scan so the highest set bit is the last to write idx.
  always_comb begin
    idx_o = ENC_IDX_NONE;
    for (int i = 0; i < ENC_IN_W; i++) begin
      if (data_i[i]) idx_o = i[ENC_OUT_W-1:0];
    end
  end

  assign valid_o = |data_i;

`ifdef ENCODER83_MULTI_DETECT_EN
  assign multi_o = ($countones(data_i) >= 2);
`endif

endmodule

// File: rtl/encoder_83.sv
// Registered 8-to-3 priority encoder; outputs update on enabled edges only.
// Optional multi-hot detection is compiled in with ENCODER83_MULTI_DETECT_EN.
module encoder_83
  import encoder83_pkg::*;
(
  input logic         iClk,
  input logic         iRst_n,
  encoder_83_if.slave bus
);

  enc_idx_t idx;
  logic     valid;
  enc_idx_t data_d, data_q;
  logic     valid_d, valid_q;

`ifdef ENCODER83_MULTI_DETECT_EN
  logic     multi;
  logic     multi_d, multi_q;

  encoder83_core u_core (
    .data_i  (bus.iData),
    .idx_o   (idx),
    .multi_o (multi),
    .valid_o (valid)
  );
`else
  encoder83_core u_core (
    .data_i  (bus.iData),
    .idx_o   (idx),
    .valid_o (valid)
  );
`endif

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (bus.iEn) begin
      data_d  = idx;
      valid_d = valid;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      data_q  <= ENC_IDX_NONE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef ENCODER83_MULTI_DETECT_EN
  always_comb begin
    multi_d = multi_q;
    if (bus.iEn) multi_d = multi;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) multi_q <= 1'b0;
    else         multi_q <= multi_d;
  end

  assign bus.oMulti = multi_q;
`else
  assign bus.oMulti = 1'b0;
`endif

  assign bus.oData  = data_q;
  assign bus.oValid = valid_q;

endmodule

// File: tb/tb_encoder_83.sv
// Self-checking bench for encoder_83: directed scenarios plus randomized
// stimulus against a highest-set-bit reference model with one-cycle latency.
module tb_encoder_83;
  logic iClk;
  logic iRst_n;
  int   n_vec;
  int   n_bad;

  encoder_83_if bus ();

  encoder_83 dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #20 iClk = ~iClk;

  // Reference: {index, valid, multi} derived from log2 and a bit-clearing popcount.
  function automatic logic [4:0] ref_out(input logic [7:0] d);
    int hi;
    int pc;
    logic [7:0] t;
    logic m;
    if (d == 8'h00) return 5'b0;
    hi = $clog2(int'(d) + 1) - 1;
    t  = d;
    pc = 0;
    while (t != 8'h00) begin
      t = t & (t - 8'd1);
      pc++;
    end
`ifdef ENCODER83_MULTI_DETECT_EN
    m = (pc >= 2);
`else
    m = 1'b0;
`endif
    return {hi[2:0], 1'b1, m};
  endfunction

  function automatic logic [4:0] dut_out();
    return {bus.oData, bus.oValid, bus.oMulti};
  endfunction

  task automatic drive(input logic en, input logic [7:0] d);
    @(negedge iClk);
    bus.iEn   = en;
    bus.iData = d;
  endtask

  task automatic after_edge();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    iRst_n    = 1'b0;
    bus.iEn   = 1'b1;
    bus.iData = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      obs = dut_out();
      n_vec++;
      if (obs !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got %b want 00000", i, obs);
      end
    end
    // First capture after release uses whatever is presented at that edge.
    drive(1'b1, 8'h20);
    iRst_n = 1'b1;
    after_edge();
    obs = dut_out();
    n_vec++;
    if (obs !== ref_out(8'h20)) begin
      n_bad++;
      $display("FAIL reset_release: got %b want %b", obs, ref_out(8'h20));
    end
    drive(1'b1, 8'hFF);
    after_edge();
    #4;
    iRst_n = 1'b0;
    #1;
    obs = dut_out();
    n_vec++;
    if (obs !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_async: got %b want 00000", obs);
    end
    after_edge();
    obs = dut_out();
    n_vec++;
    if (obs !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_overrides_en: got %b want 00000", obs);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  task automatic test_onehot();
    logic [7:0] d;
    logic [4:0] obs;
    for (int b = 7; b >= 0; b--) begin
      d = 8'h01 << b;
      drive(1'b1, d);
      after_edge();
      obs = dut_out();
      n_vec++;
      if (obs !== {b[2:0], 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL onehot bit%0d: got %b want %b", b, obs, {b[2:0], 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_zero();
    logic [4:0] obs;
    drive(1'b1, 8'h00);
    after_edge();
    obs = dut_out();
    n_vec++;
    if (obs !== 5'b000_0_0) begin
      n_bad++;
      $display("FAIL zero_input: got %b want 00000", obs);
    end
    drive(1'b1, 8'h01);
    after_edge();
    obs = dut_out();
    n_vec++;
    if (obs !== 5'b000_1_0) begin
      n_bad++;
      $display("FAIL bit0_input: got %b want 00010", obs);
    end
  endtask

  task automatic test_priority();
    logic [4:0] obs;
    logic m;
`ifdef ENCODER83_MULTI_DETECT_EN
    m = 1'b1;
`else
    m = 1'b0;
`endif
    drive(1'b1, 8'b0101_0001);
    after_edge();
    obs = dut_out();
    n_vec++;
    if (obs !== {3'd6, 1'b1, m}) begin
      n_bad++;
      $display("FAIL priority_51: got %b want %b", obs, {3'd6, 1'b1, m});
    end
    drive(1'b1, 8'hFF);
    after_edge();
    obs = dut_out();
    n_vec++;
    if (obs !== {3'd7, 1'b1, m}) begin
      n_bad++;
      $display("FAIL priority_ff: got %b want %b", obs, {3'd7, 1'b1, m});
    end
  endtask

  task automatic test_enable_hold();
    logic [4:0] obs;
    drive(1'b1, 8'b0000_1000);
    after_edge();
    obs = dut_out();
    n_vec++;
    if (obs !== 5'b011_1_0) begin
      n_bad++;
      $display("FAIL hold_capture: got %b want 01110", obs);
    end
    drive(1'b0, 8'b1000_0000);
    for (int i = 0; i < 2; i++) begin
      after_edge();
      obs = dut_out();
      n_vec++;
      if (obs !== 5'b011_1_0) begin
        n_bad++;
        $display("FAIL hold_en_low cyc%0d: got %b want 01110", i, obs);
      end
    end
    drive(1'b1, 8'b1000_0000);
    after_edge();
    obs = dut_out();
    n_vec++;
    if (obs !== 5'b111_1_0) begin
      n_bad++;
      $display("FAIL hold_reenable: got %b want 11110", obs);
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_q;
    logic [4:0] obs;
    logic       en;
    logic [7:0] d;
    exp_q = dut_out() === 5'b111_1_0 ? 5'b111_1_0 : 5'bx;
    exp_q = 5'b111_1_0;
    for (int i = 0; i < 1000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       d = 8'h01 << $urandom_range(0, 7);
        1:       d = 8'h00;
        default: d = 8'($urandom);
      endcase
      drive(en, d);
      // Mid-cycle glitch on the input must not reach the outputs.
      #5 bus.iData = ~d;
      #5 bus.iData = d;
      after_edge();
      if (en) exp_q = ref_out(d);
      obs = dut_out();
      n_vec++;
      if (obs !== exp_q) begin
        n_bad++;
        $display("FAIL random #%0d en=%b d=%h: got %b want %b", i, en, d, obs, exp_q);
      end
    end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    iRst_n    = 1'b0;
    bus.iEn   = 1'b0;
    bus.iData = 8'h00;
    test_reset();
    test_onehot();
    test_zero();
    test_priority();
    test_enable_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
